// File: rtl/ptosda_pkg.sv
// Shared types and helpers for the parallel-to-serial SDA arbiter.
package ptosda_pkg;

   // Transaction phases of the arbiter FSM
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_HI = 2'd1,
      WAIT_LO = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Serializer word width
   localparam int DW_DEF  = 4;

   // Largest requester count the helpers below support
   localparam int MAX_REQ = 8;

   // Index of the set bit in a one-hot vector (0 when the vector is empty)
   function automatic logic [2:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) idx = idx | 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ptosda_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int PW    = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [N_REQ-1:0] winner
);

   logic [2*N_REQ-1:0] dbl;
   logic [2*N_REQ-1:0] mask;
   logic [2*N_REQ-1:0] masked;
   logic               found;

   // Duplicate req, mask off positions below ptr, take the lowest survivor
   always_comb begin
      dbl    = {req, req};
      mask   = {(2*N_REQ){1'b1}} << ptr;
      masked = dbl & mask;
      winner = '0;
      found  = 1'b0;
      for (int i = 0; i < 2*N_REQ; i++) begin
         if (!found && masked[i]) begin
            found              = 1'b1;
            winner[i % N_REQ]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ptosda_arbiter.sv
// Round-robin sharing of one SDA/SCL serializer among N_REQ word sources.
module ptosda_arbiter
   import ptosda_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = 64
) (
   input  logic                sclk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*DW-1:0] req_data,
   output logic [N_REQ-1:0]    gnt,
   output logic [N_REQ-1:0]    done,
   input  logic                ser_ack,
   output logic [DW-1:0]       ser_data,
   output logic                busy,
   output logic                timeout_err
);

   localparam int PW = $clog2(N_REQ);
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   state_t               state;
   logic [PW-1:0]        ptr;
   logic [CW-1:0]        cnt;
   logic [N_REQ-1:0]     win;
   logic [DW-1:0]        sel_data;
   logic [MAX_REQ-1:0]   gnt8;
   logic [2:0]           own_idx;
   logic [PW-1:0]        ptr_adv;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .PW    (PW)
   ) u_rr (
      .req    (req),
      .ptr    (ptr),
      .winner (win)
   );

   // Word of the current round-robin winner
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win[i]) sel_data = sel_data | req_data[i*DW +: DW];
      end
   end

   // Pointer value just past the current owner, wrapping at N_REQ
   always_comb begin
      gnt8             = '0;
      gnt8[N_REQ-1:0]  = gnt;
      own_idx          = onehot2idx(gnt8);
      if (int'(own_idx) == N_REQ - 1) ptr_adv = '0;
      else                             ptr_adv = PW'(own_idx) + PW'(1);
   end

   // Transaction FSM with registered grant, data, pulses and phase timeout
   always_ff @(posedge sclk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         ptr         <= '0;
         cnt         <= '0;
         gnt         <= '0;
         done        <= '0;
         ser_data    <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         done        <= '0;
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (|win) begin
                  ser_data <= sel_data;
                  gnt      <= win;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  state    <= WAIT_HI;
               end
            end
            WAIT_HI: begin
               if (ser_ack) begin
                  cnt   <= '0;
                  state <= WAIT_LO;
               end else if (cnt == CNT_MAX) begin
                  timeout_err <= 1'b1;
                  gnt         <= '0;
                  ptr         <= ptr_adv;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            WAIT_LO: begin
               if (!ser_ack) begin
                  // Serializer has latched the word: hand done to the owner
                  done  <= gnt;
                  gnt   <= '0;
                  ptr   <= ptr_adv;
                  state <= DONE;
               end else if (cnt == CNT_MAX) begin
                  timeout_err <= 1'b1;
                  gnt         <= '0;
                  ptr         <= ptr_adv;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ptosda_arbiter.sv
// Bench for ptosda_arbiter: vector table, directed corner sequences, random vs. model.
module tb_ptosda_arbiter;

   localparam int N  = 4;
   localparam int DW = 4;
   localparam int TO = 8;

   logic            sclk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*DW-1:0] req_data;
   logic            ser_ack;
   logic [N-1:0]    gnt;
   logic [N-1:0]    done;
   logic [DW-1:0]   ser_data;
   logic            busy;
   logic            timeout_err;

   int tests = 0;
   int fails = 0;

   ptosda_arbiter #(
      .N_REQ   (N),
      .DW      (DW),
      .TIMEOUT (TO)
   ) dut (
      .sclk        (sclk),
      .rst         (rst),
      .req         (req),
      .req_data    (req_data),
      .gnt         (gnt),
      .done        (done),
      .ser_ack     (ser_ack),
      .ser_data    (ser_data),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 sclk = ~sclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   // ---------------- reference model (transaction-level) ----------------
   int          m_phase;   // 0 idle, 1 awaiting ack high, 2 awaiting ack low, 3 finishing
   int          m_owner;
   int          m_ptr;
   int          m_wait;
   logic [3:0]  m_data;
   logic [3:0]  m_done;
   logic        m_terr;

   task automatic m_reset();
      m_phase = 0; m_owner = 0; m_ptr = 0; m_wait = 0;
      m_data = '0; m_done = '0; m_terr = 1'b0;
   endtask

   function automatic int pick();
      for (int k = 0; k < N; k++) begin
         if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic m_step();
      m_done = '0;
      m_terr = 1'b0;
      case (m_phase)
         0: if (req != 0) begin
               m_owner = pick();
               m_data  = req_data[m_owner*DW +: DW];
               m_phase = 1;
               m_wait  = 0;
            end
         1: if (ser_ack) begin
               m_phase = 2; m_wait = 0;
            end else if (m_wait == TO - 1) begin
               m_terr = 1'b1; m_ptr = (m_owner + 1) % N; m_phase = 0;
            end else m_wait++;
         2: if (!ser_ack) begin
               m_phase = 3; m_done[m_owner] = 1'b1; m_ptr = (m_owner + 1) % N;
            end else if (m_wait == TO - 1) begin
               m_terr = 1'b1; m_ptr = (m_owner + 1) % N; m_phase = 0;
            end else m_wait++;
         default: m_phase = 0;
      endcase
   endtask

   task automatic m_check();
      logic [3:0] eg;
      eg = '0;
      if (m_phase == 1 || m_phase == 2) eg[m_owner] = 1'b1;
      chk("rand_gnt",  32'(gnt),         32'(eg));
      chk("rand_done", 32'(done),        32'(m_done));
      chk("rand_data", 32'(ser_data),    32'(m_data));
      chk("rand_busy", 32'(busy),        32'(m_phase != 0));
      chk("rand_terr", 32'(timeout_err), 32'(m_terr));
   endtask

   task automatic do_reset();
      rst = 1'b0; req = '0; ser_ack = 1'b0;
      tick(); tick();
      rst = 1'b1;
      m_reset();
   endtask

   // ---------------- vector table ----------------
   typedef struct packed {
      logic [3:0] req;
      logic [3:0] d0;
      logic       ack;
      logic [3:0] e_gnt;
      logic [3:0] e_data;
      logic [3:0] e_done;
      logic       e_busy;
      logic       e_terr;
   } vec_t;

   vec_t tbl [12];

   initial begin
      int n;
      int k;
      bit seen;
      int exp_idx [5];
      int bias;

      // single word A then data-hold / req-drop transaction
      tbl[0]  = '{4'b0001, 4'hA, 1'b0, 4'b0001, 4'hA, 4'b0000, 1'b1, 1'b0};
      tbl[1]  = '{4'b0001, 4'hA, 1'b1, 4'b0001, 4'hA, 4'b0000, 1'b1, 1'b0};
      tbl[2]  = '{4'b0001, 4'hA, 1'b1, 4'b0001, 4'hA, 4'b0000, 1'b1, 1'b0};
      tbl[3]  = '{4'b0001, 4'hA, 1'b1, 4'b0001, 4'hA, 4'b0000, 1'b1, 1'b0};
      tbl[4]  = '{4'b0000, 4'hA, 1'b0, 4'b0000, 4'hA, 4'b0001, 1'b1, 1'b0};
      tbl[5]  = '{4'b0000, 4'hA, 1'b0, 4'b0000, 4'hA, 4'b0000, 1'b0, 1'b0};
      tbl[6]  = '{4'b0001, 4'hA, 1'b0, 4'b0001, 4'hA, 4'b0000, 1'b1, 1'b0};
      tbl[7]  = '{4'b0000, 4'h5, 1'b0, 4'b0001, 4'hA, 4'b0000, 1'b1, 1'b0};
      tbl[8]  = '{4'b0000, 4'h5, 1'b1, 4'b0001, 4'hA, 4'b0000, 1'b1, 1'b0};
      tbl[9]  = '{4'b0000, 4'h5, 1'b0, 4'b0000, 4'hA, 4'b0001, 1'b1, 1'b0};
      tbl[10] = '{4'b0000, 4'h5, 1'b0, 4'b0000, 4'hA, 4'b0000, 1'b0, 1'b0};
      tbl[11] = '{4'b0000, 4'h5, 1'b0, 4'b0000, 4'hA, 4'b0000, 1'b0, 1'b0};

      // asynchronous reset at start
      rst = 1'b1; req = '0; req_data = '0; ser_ack = 1'b0;
      #2 rst = 1'b0;
      #2;
      chk("rst_gnt",  32'(gnt),         32'h0);
      chk("rst_done", 32'(done),        32'h0);
      chk("rst_data", 32'(ser_data),    32'h0);
      chk("rst_busy", 32'(busy),        32'h0);
      chk("rst_terr", 32'(timeout_err), 32'h0);
      tick(); tick();
      rst = 1'b1;

      for (int i = 0; i < 12; i++) begin
         req      = tbl[i].req;
         req_data = {12'h000, tbl[i].d0};
         ser_ack  = tbl[i].ack;
         tick();
         chk($sformatf("vec%0d_gnt", i),  32'(gnt),         32'(tbl[i].e_gnt));
         chk($sformatf("vec%0d_data", i), 32'(ser_data),    32'(tbl[i].e_data));
         chk($sformatf("vec%0d_done", i), 32'(done),        32'(tbl[i].e_done));
         chk($sformatf("vec%0d_busy", i), 32'(busy),        32'(tbl[i].e_busy));
         chk($sformatf("vec%0d_terr", i), 32'(timeout_err), 32'(tbl[i].e_terr));
      end

      // reset mid-WAIT_LO (pointer currently 1)
      req_data = {4'h4, 4'h3, 4'h2, 4'h1};
      req = 4'b0100;
      tick();
      chk("mid_gnt", 32'(gnt), 32'h4);
      chk("mid_data", 32'(ser_data), 32'h3);
      req = '0; ser_ack = 1'b1;
      tick(); tick();
      #3 rst = 1'b0;
      #1;
      chk("arst_gnt",  32'(gnt),         32'h0);
      chk("arst_done", 32'(done),        32'h0);
      chk("arst_data", 32'(ser_data),    32'h0);
      chk("arst_busy", 32'(busy),        32'h0);
      chk("arst_terr", 32'(timeout_err), 32'h0);
      tick();
      chk("arst_hold_done", 32'(done), 32'h0);
      rst = 1'b1; req = 4'b1111; ser_ack = 1'b0;
      tick();
      chk("arst_ptr0_gnt", 32'(gnt), 32'h1);
      chk("arst_ptr0_data", 32'(ser_data), 32'h1);

      // round robin with all requests held
      do_reset();
      exp_idx = '{0, 1, 2, 3, 0};
      req = 4'b1111;
      req_data = {4'h4, 4'h3, 4'h2, 4'h1};
      for (int t = 0; t < 5; t++) begin
         k = 0;
         while (gnt == 0 && k < 10) begin tick(); k++; end
         chk($sformatf("rr%0d_gnt", t),  32'(gnt),      32'(1 << exp_idx[t]));
         chk($sformatf("rr%0d_data", t), 32'(ser_data), 32'(exp_idx[t] + 1));
         ser_ack = 1'b1;
         tick(); tick();
         ser_ack = 1'b0;
         k = 0;
         seen = 1'b0;
         while (!seen && k < 10) begin
            tick(); k++;
            if (done != 0) begin
               seen = 1'b1;
               chk($sformatf("rr%0d_done", t), 32'(done), 32'(1 << exp_idx[t]));
            end
         end
         if (!seen) chk($sformatf("rr%0d_done_seen", t), 32'(seen), 32'h1);
      end

      // timeout with ack stuck low
      do_reset();
      req = 4'b0011;
      ser_ack = 1'b0;
      tick();
      chk("to_gnt0", 32'(gnt), 32'h1);
      n = 0;
      seen = 1'b0;
      for (int j = 0; j < 20; j++) begin
         tick();
         n++;
         if (done != 0) seen = 1'b1;
         if (timeout_err) break;
      end
      chk("to_cycles", 32'(n), 32'd8);
      chk("to_gnt_clr", 32'(gnt), 32'h0);
      chk("to_no_done", 32'(seen), 32'h0);
      tick();
      chk("to_next_gnt", 32'(gnt), 32'h2);
      chk("to_pulse1", 32'(timeout_err), 32'h0);

      // early ack: already high when the grant appears
      do_reset();
      ser_ack = 1'b1;
      tick();
      req = 4'b0001;
      req_data = {4'h4, 4'h3, 4'h2, 4'hC};
      tick();
      chk("early_gnt", 32'(gnt), 32'h1);
      req = '0;
      tick();
      chk("early_hold", 32'(gnt), 32'h1);
      ser_ack = 1'b0;
      tick();
      chk("early_done", 32'(done), 32'h1);
      chk("early_data", 32'(ser_data), 32'hC);
      chk("early_terr", 32'(timeout_err), 32'h0);

      // random stimulus against the model
      do_reset();
      bias = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 0) begin
            case ($urandom_range(0, 2))
               0:       bias = 50;
               1:       bias = 4;
               default: bias = 96;
            endcase
         end
         req      = 4'($urandom_range(0, 15));
         req_data = 16'($urandom);
         ser_ack  = ($urandom_range(0, 99) < bias);
         m_step();
         tick();
         m_check();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
